rx_pkt_framer: RTL and testbench
================================

# rx_pkt_framer

USB full-speed receive packet framer. Consumes the NRZI-decoded serial bit stream from the line receiver. It detects SYNC, removes stuffed bits, captures and validates the PID, assembles payload bytes, and drives the serial CRC checker. It selects CRC5 or CRC16, feeds payload bits, requests the check at EOP, and folds the checker's result into a per-packet status for the protocol engine.

## Interface
Parameters:
- SYNC_MIN, 3: minimum consecutive decoded zeros before the SYNC-terminating one is accepted.

Ports (one clock; reset is synchronous and active-high):
- clk_c  in  1  system clock, 4x or more the bit rate
- reset  in  1  synchronous, active-high
- rx_valid  in  1  one-cycle strobe per received line bit
- rx_bit  in  1  NRZI-decoded bit, qualified by rx_valid
- se0  in  1  line SE0, qualified by rx_valid
- crc_error  in  1  CRC checker error result
- crc_bit  out  1  serial bit to CRC checker
- crc_rcs  out  1  one-cycle shift enable to CRC checker, one per payload bit
- crc_cwe_z  out  1  high while in DATA (checker accumulating); low otherwise (checker preset)
- crc_chck  out  1  one-cycle check request
- crc_sel16  out  1  1 = CRC16, 0 = CRC5; valid from PID accept to pkt_end
- pkt_start  out  1  one-cycle pulse on SYNC detect
- pid  out  4  accepted PID, low nibble
- pid_valid  out  1  one-cycle pulse when PID accepted
- rx_data  out  8  payload byte, LSB received first
- byte_valid  out  1  one-cycle pulse per payload byte
- pkt_end  out  1  one-cycle pulse; status outputs valid
- err_pid, err_stuff, err_crc, err_align  out  1 each  latched status; cleared on pkt_start

## Operation
- All outputs reset to 0. The FSM resets to IDLE, and all counters and shift registers reset to 0.
- The FSM advances only on rx_valid, except in CHECK and DONE.
- FSM states: IDLE, PID, DATA, FLUSH, CHECK, DONE.
- IDLE: counts consecutive zero bits. A one after at least SYNC_MIN zeros pulses pkt_start, clears the error flags, sets the ones count to 1, and moves to PID. SE0 in IDLE is ignored.
- Unstuffing applies in PID and DATA. Each one increments the ones count; each zero clears it.
  - When the ones count reaches 6, the next bit is a stuff bit and is discarded.
  - A zero stuff bit clears the count.
  - A one stuff bit sets err_stuff and moves to FLUSH.
- PID: shifts 8 unstuffed bits, LSB first.
  - If pid[7:4] == ~pid[3:0]: pulse pid_valid, present pid[3:0], and move to DATA.
  - Otherwise: set err_pid and move to FLUSH.
- PID classification:
  - crc_sel16 = 1 for data PIDs (pid[1:0] == 2'b11).
  - crc_sel16 = 0 for tokens (pid[1:0] == 2'b01).
  - Handshake and special PIDs (pid[1:0] == 2'b10 or 2'b00) use no CRC.
- DATA: each unstuffed bit is driven on crc_bit with crc_rcs for one cycle, and shifted into the byte register. Every 8th bit pulses byte_valid with rx_data. crc_rcs is suppressed for no-CRC PIDs.
- EOP is two consecutive rx_valid strobes with se0 = 1. The first SE0 strobe is neither shifted nor counted.
- EOP in DATA:
  - Bit count mod 8 != 0 sets err_align.
  - Otherwise, a CRC PID goes to CHECK; a no-CRC PID goes to DONE.
- EOP in PID sets err_align and goes to DONE.
- FLUSH: ignores bits until EOP, then goes to DONE. No byte_valid and no crc_chck are issued.
- CHECK: pulses crc_chck for one cycle. The next cycle samples crc_error into err_crc, then goes to DONE.
- DONE: pulses pkt_end for one cycle and returns to IDLE. Error flags and pid hold until the next pkt_start.
- Reset mid-packet: returns to IDLE the next cycle. No pkt_end is issued, and all flags are cleared.

## Timing
- rx_valid strobes are at least 4 cycles apart. The sequencing below relies on this.
- crc_rcs, byte_valid, pid_valid and pkt_start occur in the cycle after the qualifying rx_valid.
- EOP-detect strobe at cycle N, for CRC PIDs:
  - crc_chck at N+1.
  - crc_error sampled at N+2.
  - pkt_end at N+3.
- EOP-detect strobe at cycle N, for no-CRC PIDs and error paths: pkt_end at N+1.
- crc_cwe_z rises with the first DATA bit and falls at the crc_chck cycle.

## Structure
- Shared package/defines file usb_rx_defs: state encodings, PID type codes (TOKEN = 2'b01, DATA = 2'b11, HANDSHAKE = 2'b10), and the stuff limit 6.
- One sub-module, bit_unstuff:
  - Inputs: rx_valid, rx_bit, and a clear.
  - Outputs: bit_valid, bit, stuff_err.
  - Covers the ones counter and the discard logic.
- The framer FSM, byte assembler and CRC sequencing sit in rx_pkt_framer.

## Test plan
- SYNC 00000001, then PID 0xE1 (OUT), then 16 token bits with a correct CRC5, then 2×SE0. Required: pid_valid with pid = 4'h1, crc_sel16 = 0, 2 byte_valid, crc_chck, pkt_end, all error flags 0.
- DATA0 (PID 0xC3) with payload 8'hFF, 8'hFF and a correct CRC16, stuffed bits inserted. Required: stuffed zeros removed, rx_data = 8'hFF twice, crc_sel16 = 1, err_crc = 0.
- Seven consecutive ones in the payload. Required: err_stuff = 1, no further byte_valid, no crc_chck, pkt_end after EOP.
- PID 0xE2 (nibbles not complementary). Required: err_pid = 1, no crc_rcs, pkt_end after EOP.
- ACK (0xD2), then EOP. Required: pkt_end at N+1, no crc_chck. DATA1 with EOP after 13 payload bits: err_align = 1.
- crc_error forced to 1 at check time: err_crc = 1. Reset asserted mid-DATA: all outputs 0 the next cycle, no pkt_end, and a new packet is received correctly afterwards.

Source files
------------

// File: rtl/usb_rx_defs.sv
// Shared definitions for the USB full-speed receive path: framer states,
// PID type codes carried in pid[1:0], and the bit-stuffing run length.
package usb_rx_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_FLUSH,
        ST_CHECK,
        ST_DONE
    } framer_state_e;

    typedef enum logic [1:0] {
        PT_SPECIAL   = 2'b00,
        PT_TOKEN     = 2'b01,
        PT_HANDSHAKE = 2'b10,
        PT_DATA      = 2'b11
    } pid_type_e;

    localparam int unsigned STUFF_LIMIT = 6;

    // Tokens carry CRC5 and data packets CRC16; handshake/special carry none.
    function automatic logic pid_uses_crc(input pid_type_e t);
        return (t == PT_TOKEN) || (t == PT_DATA);
    endfunction

endpackage

// File: rtl/bit_unstuff.sv
// Bit unstuffer: tracks the run of consecutive ones and discards the bit
// that follows six ones. A one in the stuff position is a stuffing error.
module bit_unstuff
    import usb_rx_defs::*;
(
    input  logic clk_c,
    input  logic reset,
    input  logic rx_valid_i,
    input  logic rx_bit_i,
    input  logic clear_i,
    output logic bit_valid_o,
    output logic bit_o,
    output logic stuff_err_o
);

    logic [2:0] ones_q;
    logic [2:0] ones_d;
    logic       at_limit;

    assign at_limit    = (ones_q == 3'(STUFF_LIMIT));
    assign bit_o       = rx_bit_i;
    assign bit_valid_o = rx_valid_i && !clear_i && !at_limit;
    assign stuff_err_o = rx_valid_i && !clear_i && at_limit && rx_bit_i;

    // Next ones count. While cleared the count tracks only the latest bit,
    // so the SYNC-terminating one enters PID with a count of 1.
    always_comb begin
        ones_d = ones_q;
        if (clear_i) begin
            ones_d = (rx_valid_i && rx_bit_i) ? 3'd1 : 3'd0;
        end else if (rx_valid_i) begin
            if (at_limit || !rx_bit_i) begin
                ones_d = '0;
            end else begin
                ones_d = ones_q + 3'd1;
            end
        end
    end

    // Ones-count register.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/rx_pkt_framer.sv
// USB full-speed receive packet framer: SYNC detection, PID capture and
// validation, payload byte assembly and serial CRC checker sequencing.
module rx_pkt_framer
    import usb_rx_defs::*;
#(
    parameter int unsigned SYNC_MIN = 3
) (
    input  logic       clk_c,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic       rx_bit,
    input  logic       se0,
    input  logic       crc_error,
    output logic       crc_bit,
    output logic       crc_rcs,
    output logic       crc_cwe_z,
    output logic       crc_chck,
    output logic       crc_sel16,
    output logic       pkt_start,
    output logic [3:0] pid,
    output logic       pid_valid,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       pkt_end,
    output logic       err_pid,
    output logic       err_stuff,
    output logic       err_crc,
    output logic       err_align
);

    localparam int unsigned ZW = $clog2(SYNC_MIN + 1);

    framer_state_e state_q;
    logic [ZW-1:0] zeros_q;
    logic          se0_seen_q;
    logic [7:0]    sh_q;
    logic [7:0]    sh_d;
    logic [2:0]    bitcnt_q;
    logic [2:0]    bitcnt_d;
    logic          use_crc_q;
    logic          chk_phase_q;
    logic          eop;

    logic          ub_clear;
    logic          ub_valid;
    logic          ub_bit;
    logic          ub_err;

    logic          crc_bit_q, crc_rcs_q, crc_cwe_z_q, crc_chck_q, crc_sel16_q;
    logic          pkt_start_q, pid_valid_q, byte_valid_q, pkt_end_q;
    logic [3:0]    pid_q;
    logic [7:0]    rx_data_q;
    logic          err_pid_q, err_stuff_q, err_crc_q, err_align_q;

    // SE0 strobes never reach the unstuffer, so EOP neither shifts nor counts.
    bit_unstuff u_unstuff (
        .clk_c       (clk_c),
        .reset       (reset),
        .rx_valid_i  (rx_valid && !se0),
        .rx_bit_i    (rx_bit),
        .clear_i     (ub_clear),
        .bit_valid_o (ub_valid),
        .bit_o       (ub_bit),
        .stuff_err_o (ub_err)
    );

    // Datapath helpers: unstuff enable, LSB-first shift, bit count, EOP.
    always_comb begin
        ub_clear = (state_q != ST_PID) && (state_q != ST_DATA);
        sh_d     = {ub_bit, sh_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        eop      = rx_valid && se0 && se0_seen_q;
    end

    // Framer FSM with registered outputs and status flags.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            zeros_q      <= '0;
            se0_seen_q   <= 1'b0;
            sh_q         <= '0;
            bitcnt_q     <= '0;
            use_crc_q    <= 1'b0;
            chk_phase_q  <= 1'b0;
            crc_bit_q    <= 1'b0;
            crc_rcs_q    <= 1'b0;
            crc_cwe_z_q  <= 1'b0;
            crc_chck_q   <= 1'b0;
            crc_sel16_q  <= 1'b0;
            pkt_start_q  <= 1'b0;
            pid_q        <= '0;
            pid_valid_q  <= 1'b0;
            rx_data_q    <= '0;
            byte_valid_q <= 1'b0;
            pkt_end_q    <= 1'b0;
            err_pid_q    <= 1'b0;
            err_stuff_q  <= 1'b0;
            err_crc_q    <= 1'b0;
            err_align_q  <= 1'b0;
        end else begin
            pkt_start_q  <= 1'b0;
            pid_valid_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            crc_rcs_q    <= 1'b0;
            crc_chck_q   <= 1'b0;
            pkt_end_q    <= 1'b0;

            // An SE0 arms EOP; a second consecutive SE0 strobe completes it.
            if (rx_valid) begin
                se0_seen_q <= se0 && !se0_seen_q && (state_q != ST_IDLE);
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && !se0) begin
                        if (!rx_bit) begin
                            if (zeros_q != ZW'(SYNC_MIN)) begin
                                zeros_q <= zeros_q + ZW'(1);
                            end
                        end else begin
                            zeros_q <= '0;
                            if (zeros_q == ZW'(SYNC_MIN)) begin
                                pkt_start_q <= 1'b1;
                                err_pid_q   <= 1'b0;
                                err_stuff_q <= 1'b0;
                                err_crc_q   <= 1'b0;
                                err_align_q <= 1'b0;
                                pid_q       <= '0;
                                crc_sel16_q <= 1'b0;
                                use_crc_q   <= 1'b0;
                                bitcnt_q    <= '0;
                                state_q     <= ST_PID;
                            end
                        end
                    end
                end

                ST_PID: begin
                    if (eop) begin
                        err_align_q <= 1'b1;
                        pkt_end_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (ub_err) begin
                        err_stuff_q <= 1'b1;
                        state_q     <= ST_FLUSH;
                    end else if (ub_valid) begin
                        sh_q     <= sh_d;
                        bitcnt_q <= bitcnt_d;
                        if (bitcnt_q == 3'd7) begin
                            if (sh_d[7:4] == ~sh_d[3:0]) begin
                                pid_q       <= sh_d[3:0];
                                pid_valid_q <= 1'b1;
                                crc_sel16_q <= (pid_type_e'(sh_d[1:0]) == PT_DATA);
                                use_crc_q   <= pid_uses_crc(pid_type_e'(sh_d[1:0]));
                                state_q     <= ST_DATA;
                            end else begin
                                err_pid_q <= 1'b1;
                                state_q   <= ST_FLUSH;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (eop) begin
                        crc_cwe_z_q <= 1'b0;
                        if (bitcnt_q != 3'd0) begin
                            err_align_q <= 1'b1;
                            pkt_end_q   <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (use_crc_q) begin
                            crc_chck_q  <= 1'b1;
                            chk_phase_q <= 1'b0;
                            state_q     <= ST_CHECK;
                        end else begin
                            pkt_end_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end else if (ub_err) begin
                        crc_cwe_z_q <= 1'b0;
                        err_stuff_q <= 1'b1;
                        state_q     <= ST_FLUSH;
                    end else if (ub_valid) begin
                        crc_bit_q   <= ub_bit;
                        crc_rcs_q   <= use_crc_q;
                        crc_cwe_z_q <= 1'b1;
                        sh_q        <= sh_d;
                        bitcnt_q    <= bitcnt_d;
                        if (bitcnt_q == 3'd7) begin
                            rx_data_q    <= sh_d;
                            byte_valid_q <= 1'b1;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (eop) begin
                        pkt_end_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end

                // Two cycles: the first carries crc_chck, the second samples the result.
                ST_CHECK: begin
                    if (!chk_phase_q) begin
                        chk_phase_q <= 1'b1;
                    end else begin
                        chk_phase_q <= 1'b0;
                        err_crc_q   <= crc_error;
                        pkt_end_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign crc_bit    = crc_bit_q;
    assign crc_rcs    = crc_rcs_q;
    assign crc_cwe_z  = crc_cwe_z_q;
    assign crc_chck   = crc_chck_q;
    assign crc_sel16  = crc_sel16_q;
    assign pkt_start  = pkt_start_q;
    assign pid        = pid_q;
    assign pid_valid  = pid_valid_q;
    assign rx_data    = rx_data_q;
    assign byte_valid = byte_valid_q;
    assign pkt_end    = pkt_end_q;
    assign err_pid    = err_pid_q;
    assign err_stuff  = err_stuff_q;
    assign err_crc    = err_crc_q;
    assign err_align  = err_align_q;

endmodule

// File: tb/tb_rx_pkt_framer.sv
// Directed bench for rx_pkt_framer: transmits stuffed USB packets one line
// bit every 4 clocks and checks framing, status flags and CRC sequencing.
module tb_rx_pkt_framer;

    logic       clk_c = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic       rx_bit;
    logic       se0;
    logic       crc_error;
    logic       crc_bit, crc_rcs, crc_cwe_z, crc_chck, crc_sel16, pkt_start;
    logic [3:0] pid;
    logic       pid_valid;
    logic [7:0] rx_data;
    logic       byte_valid, pkt_end;
    logic       err_pid, err_stuff, err_crc, err_align;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitors
    int          n_start = 0, n_pidv = 0, n_bv = 0, n_rcs = 0, n_chck = 0, n_end = 0, n_cwe_bad = 0;
    logic [7:0]  byte_log [64];
    logic [31:0] crc_log = '0;
    int          b_start, b_pidv, b_bv, b_rcs, b_chck, b_end;
    int          tx_ones;

    rx_pkt_framer #(.SYNC_MIN(3)) dut (
        .clk_c      (clk_c),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_bit     (rx_bit),
        .se0        (se0),
        .crc_error  (crc_error),
        .crc_bit    (crc_bit),
        .crc_rcs    (crc_rcs),
        .crc_cwe_z  (crc_cwe_z),
        .crc_chck   (crc_chck),
        .crc_sel16  (crc_sel16),
        .pkt_start  (pkt_start),
        .pid        (pid),
        .pid_valid  (pid_valid),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .pkt_end    (pkt_end),
        .err_pid    (err_pid),
        .err_stuff  (err_stuff),
        .err_crc    (err_crc),
        .err_align  (err_align)
    );

    always #5 clk_c = ~clk_c;

    always @(negedge clk_c) begin
        if (pkt_start) n_start <= n_start + 1;
        if (pid_valid) n_pidv <= n_pidv + 1;
        if (byte_valid) begin
            byte_log[n_bv % 64] <= rx_data;
            n_bv <= n_bv + 1;
        end
        if (crc_rcs) begin
            n_rcs   <= n_rcs + 1;
            crc_log <= {crc_bit, crc_log[31:1]};
            if (!crc_cwe_z) n_cwe_bad <= n_cwe_bad + 1;
        end
        if (crc_chck) n_chck <= n_chck + 1;
        if (pkt_end) n_end <= n_end + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic b, input logic s);
        rx_valid = 1'b1;
        rx_bit   = b;
        se0      = s;
        @(negedge clk_c);
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
        se0      = 1'b0;
        repeat (3) @(negedge clk_c);
    endtask

    // Transmit-side stuffer: a zero follows every sixth consecutive one.
    task automatic send_bit(input logic b);
        line(b, 1'b0);
        if (b) begin
            tx_ones++;
            if (tx_ones == 6) begin
                line(1'b0, 1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_sync(input int zeros);
        for (int i = 0; i < zeros; i++) line(1'b0, 1'b0);
        line(1'b1, 1'b0);
        tx_ones = 1;
    endtask

    task automatic snap();
        b_start = n_start; b_pidv = n_pidv; b_bv = n_bv;
        b_rcs = n_rcs; b_chck = n_chck; b_end = n_end;
    endtask

    task automatic eop_crc(input logic crc_val);
        crc_error = ~crc_val;
        line(1'b0, 1'b1);
        rx_valid = 1'b1;
        se0      = 1'b1;
        @(negedge clk_c);
        rx_valid = 1'b0;
        se0      = 1'b0;
        check("chck_n1", {31'b0, crc_chck}, 1);
        check("cwe_n1", {31'b0, crc_cwe_z}, 0);
        check("end_n1", {31'b0, pkt_end}, 0);
        @(negedge clk_c);
        crc_error = crc_val;
        check("chck_n2", {31'b0, crc_chck}, 0);
        check("end_n2", {31'b0, pkt_end}, 0);
        @(negedge clk_c);
        crc_error = ~crc_val;
        check("end_n3", {31'b0, pkt_end}, 1);
        repeat (3) @(negedge clk_c);
        crc_error = 1'b1;
    endtask

    task automatic eop_nocrc();
        line(1'b0, 1'b1);
        rx_valid = 1'b1;
        se0      = 1'b1;
        @(negedge clk_c);
        rx_valid = 1'b0;
        se0      = 1'b0;
        check("end_n1", {31'b0, pkt_end}, 1);
        check("chck_n1", {31'b0, crc_chck}, 0);
        @(negedge clk_c);
        check("end_n2", {31'b0, pkt_end}, 0);
        repeat (3) @(negedge clk_c);
    endtask

    // Per-packet deltas and {err_pid, err_stuff, err_crc, err_align}.
    task automatic expect_pkt(input string t, input int e_pidv, input int e_bv,
                              input int e_rcs, input int e_chck, input logic [3:0] e_err);
        check({t, "_start"}, n_start - b_start, 1);
        check({t, "_pidv"}, n_pidv - b_pidv, e_pidv);
        check({t, "_bytes"}, n_bv - b_bv, e_bv);
        check({t, "_rcs"}, n_rcs - b_rcs, e_rcs);
        check({t, "_chck"}, n_chck - b_chck, e_chck);
        check({t, "_end"}, n_end - b_end, 1);
        check({t, "_errs"}, {28'b0, err_pid, err_stuff, err_crc, err_align}, {28'b0, e_err});
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_bit    = 1'b0;
        se0       = 1'b0;
        crc_error = 1'b1;
        tx_ones   = 0;
        repeat (3) @(negedge clk_c);
        check("reset_outs", {7'b0, crc_bit, crc_rcs, crc_cwe_z, crc_chck, crc_sel16, pkt_start,
              pid, pid_valid, rx_data, byte_valid, pkt_end, err_pid, err_stuff, err_crc, err_align}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_c);

        // OUT token, addr 0 endp 0
        snap();
        send_sync(7);
        send_byte(8'hE1);
        send_byte(8'h00);
        send_byte(8'h10);
        eop_crc(1'b0);
        expect_pkt("tok", 1, 2, 16, 1, 4'b0000);
        check("tok_pid", {28'b0, pid}, 32'h1);
        check("tok_sel16", {31'b0, crc_sel16}, 0);
        check("tok_b0", {24'b0, byte_log[b_bv % 64]}, 32'h00);
        check("tok_b1", {24'b0, byte_log[(b_bv + 1) % 64]}, 32'h10);
        check("tok_crcbits", {16'b0, crc_log[31:16]}, 32'h1000);

        // DATA0 FF FF with CRC16 FF FF: 32 ones, 5 stuffed zeros
        snap();
        send_sync(7);
        send_byte(8'hC3);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        eop_crc(1'b0);
        expect_pkt("d0", 1, 4, 32, 1, 4'b0000);
        check("d0_pid", {28'b0, pid}, 32'h3);
        check("d0_sel16", {31'b0, crc_sel16}, 1);
        for (int i = 0; i < 4; i++)
            check("d0_byte", {24'b0, byte_log[(b_bv + i) % 64]}, 32'hFF);
        check("d0_crcbits", crc_log, 32'hFFFF_FFFF);

        // Seven consecutive ones inside the payload
        snap();
        send_sync(7);
        send_byte(8'hC3);
        send_byte(8'h00);
        for (int i = 0; i < 7; i++) line(1'b1, 1'b0);
        line(1'b0, 1'b0);
        line(1'b1, 1'b0);
        eop_nocrc();
        expect_pkt("stuff", 1, 1, 14, 0, 4'b0100);
        check("stuff_b0", {24'b0, byte_log[b_bv % 64]}, 32'h00);

        // PID with non-complementary nibbles
        snap();
        send_sync(7);
        send_byte(8'hE2);
        send_byte(8'h55);
        eop_nocrc();
        expect_pkt("badpid", 0, 0, 0, 0, 4'b1000);

        // Two zeros are short of SYNC_MIN; exactly three then start an ACK
        snap();
        line(1'b0, 1'b0);
        line(1'b0, 1'b0);
        line(1'b1, 1'b0);
        check("short_sync", n_start - b_start, 0);
        send_sync(3);
        send_byte(8'hD2);
        eop_nocrc();
        expect_pkt("ack", 1, 0, 0, 0, 4'b0000);
        check("ack_pid", {28'b0, pid}, 32'h2);
        check("ack_sel16", {31'b0, crc_sel16}, 0);

        // DATA1 with 13 payload bits
        snap();
        send_sync(7);
        send_byte(8'h4B);
        send_byte(8'hA5);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        eop_nocrc();
        expect_pkt("align", 1, 1, 13, 0, 4'b0001);
        check("align_b0", {24'b0, byte_log[b_bv % 64]}, 32'hA5);

        // CRC checker reports an error
        snap();
        send_sync(7);
        send_byte(8'hE1);
        send_byte(8'h00);
        send_byte(8'h10);
        eop_crc(1'b1);
        expect_pkt("crcerr", 1, 2, 16, 1, 4'b0010);

        // Reset in the middle of a DATA0 payload
        snap();
        send_sync(7);
        send_byte(8'hC3);
        send_byte(8'h5A);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b1;
        @(negedge clk_c);
        reset = 1'b0;
        check("midrst_outs", {7'b0, crc_bit, crc_rcs, crc_cwe_z, crc_chck, crc_sel16, pkt_start,
              pid, pid_valid, rx_data, byte_valid, pkt_end, err_pid, err_stuff, err_crc, err_align}, 0);
        repeat (12) @(negedge clk_c);
        check("midrst_noend", n_end - b_end, 0);

        // Normal token after the reset
        snap();
        send_sync(7);
        send_byte(8'hE1);
        send_byte(8'h00);
        send_byte(8'h10);
        eop_crc(1'b0);
        expect_pkt("post", 1, 2, 16, 1, 4'b0000);
        check("post_pid", {28'b0, pid}, 32'h1);
        check("cwe_during_rcs", n_cwe_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
